// File: rtl/soc_ahb3_pkg.sv
// ---------------------------------------------------------------------------
// soc_ahb3_pkg
// Shared AHB3-Lite encodings and the SRAM bridge state type.
//   HTRANS_*  : transfer type encodings
//   HSIZE_*   : transfer size encodings (byte/halfword/word)
//   HRESP_*   : response encodings
//   bridge_state_e : soc_ahb3_sram_sp_bridge FSM states
// ---------------------------------------------------------------------------
package soc_ahb3_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_WR_STALL,
      ST_ERR1,
      ST_ERR2
   } bridge_state_e;

endpackage

// File: rtl/soc_ahb3_sram_lane_decode.sv
// ---------------------------------------------------------------------------
// soc_ahb3_sram_lane_decode
// Combinational little-endian byte-lane decode for an AHB transfer.
//   hsize_i    : HSIZE of the address phase
//   addr_lo_i  : HADDR[1:0]
//   sel_o      : byte-lane selects (zero when the size is illegal)
//   misalign_o : address not aligned to the transfer size
//   size_err_o : transfer wider than the data bus
// ---------------------------------------------------------------------------
module soc_ahb3_sram_lane_decode
   import soc_ahb3_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]          hsize_i,
   input  logic [1:0]          addr_lo_i,
   output logic [XLEN/8-1:0]   sel_o,
   output logic                misalign_o,
   output logic                size_err_o
);

   localparam int SW  = XLEN / 8;
   localparam int LSW = $clog2(SW);

   logic [1:0] amask;
   int         off;

   always_comb begin
      size_err_o = (int'(hsize_i) > LSW);
      case (hsize_i)
         HSIZE_BYTE:  amask = 2'b00;
         HSIZE_HWORD: amask = 2'b01;
         HSIZE_WORD:  amask = 2'b11;
         default:     amask = 2'b00;
      endcase
      misalign_o = (|(addr_lo_i & amask)) & ~size_err_o;
      // Byte offset within the bus word; a lane is selected when it falls in
      // the same size-aligned block as the offset.
      off = int'(addr_lo_i) & (SW - 1);
      for (int i = 0; i < SW; i++) begin
         sel_o[i] = ~size_err_o && ((i >> hsize_i) == (off >> hsize_i));
      end
   end

endmodule

// File: rtl/soc_ahb3_sram_sp_bridge.sv
// ---------------------------------------------------------------------------
// soc_ahb3_sram_sp_bridge
// AHB3-Lite slave in front of a single-port SRAM with 1-cycle read latency.
//   clk, rst          : clock, asynchronous active-high reset
//   HSEL..HREADY      : AHB3-Lite slave inputs (HBURST/HPROT/HMASTLOCK ignored)
//   HRDATA/HREADYOUT/HRESP : AHB3-Lite slave outputs
//   sram_ce/we/oe/waddr/din/sel : SRAM control, word address, data, byte lanes
//   sram_dout         : SRAM read data, valid the cycle after a read strobe
// Reads issue in the address phase (zero wait). Writes issue in the data
// phase from a registered address; a read arriving during a write data phase
// is held for one cycle (WR_STALL). Illegal transfers get a 2-cycle ERROR.
// ---------------------------------------------------------------------------
module soc_ahb3_sram_sp_bridge
   import soc_ahb3_pkg::*;
#(
   parameter int          PLEN          = 32,
   parameter int          XLEN          = 32,
   parameter int          WORD_AW       = PLEN - ((XLEN / 8) >> 1),
   parameter int unsigned MEM_SIZE_BYTE = 'h10000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                HSEL,
   input  logic [PLEN-1:0]     HADDR,
   input  logic [XLEN-1:0]     HWDATA,
   input  logic                HWRITE,
   input  logic [2:0]          HSIZE,
   input  logic [2:0]          HBURST,
   input  logic [3:0]          HPROT,
   input  logic [1:0]          HTRANS,
   input  logic                HMASTLOCK,
   input  logic                HREADY,
   output logic [XLEN-1:0]     HRDATA,
   output logic                HREADYOUT,
   output logic                HRESP,
   output logic                sram_ce,
   output logic                sram_we,
   output logic                sram_oe,
   output logic [WORD_AW-1:0]  sram_waddr,
   output logic [XLEN-1:0]     sram_din,
   output logic [XLEN/8-1:0]   sram_sel,
   input  logic [XLEN-1:0]     sram_dout
);

   localparam int             SW      = XLEN / 8;
   localparam int             AW_OFF  = SW >> 1;
   localparam logic [PLEN:0]  MEM_LIM = (PLEN + 1)'(MEM_SIZE_BYTE);

   bridge_state_e      state_q, state_d;
   logic [WORD_AW-1:0] waddr_q, waddr_d;
   logic [SW-1:0]      sel_q, sel_d;

   logic [SW-1:0]      dec_sel;
   logic               dec_misalign, dec_size_err, dec_range_err, dec_err;
   logic [WORD_AW-1:0] haddr_word;
   logic               active, acc, can_acc, take;
   logic               collide, rd_take, wr_take, err_take, rd_issue;

   logic unused_in;
   assign unused_in = ^{HBURST, HPROT, HMASTLOCK};

   soc_ahb3_sram_lane_decode #(.XLEN(XLEN)) u_dec (
      .hsize_i    (HSIZE),
      .addr_lo_i  (HADDR[1:0]),
      .sel_o      (dec_sel),
      .misalign_o (dec_misalign),
      .size_err_o (dec_size_err)
   );

   assign dec_range_err = ({1'b0, HADDR} >= MEM_LIM);
   assign dec_err       = dec_size_err | dec_misalign | dec_range_err;
   assign haddr_word    = WORD_AW'(HADDR >> AW_OFF);

   // Reset gates acceptance so no SRAM strobe can leak out while rst is high.
   assign active = HSEL & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ)) & ~rst;
   assign acc    = active & HREADY;

   // During a write data phase this slave owns HREADY, so the collision is
   // detected without HREADY to avoid a combinational loop through the bus.
   assign collide  = (state_q == ST_WR) & active & ~HWRITE & ~dec_err;
   assign can_acc  = ((state_q == ST_IDLE) | (state_q == ST_RD) |
                      (state_q == ST_WR)   | (state_q == ST_ERR2)) & ~collide;
   assign take     = acc & can_acc;
   assign rd_take  = take & ~dec_err & ~HWRITE;
   assign wr_take  = take & ~dec_err &  HWRITE;
   assign err_take = take &  dec_err;
   // WR_STALL replays the held read; HADDR is stable while HREADY was low.
   assign rd_issue = rd_take | (state_q == ST_WR_STALL);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waddr_q <= '0;
         sel_q   <= '0;
      end else begin
         waddr_q <= waddr_d;
         sel_q   <= sel_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      sel_d   = sel_q;
      case (state_q)
         ST_ERR1:     state_d = ST_ERR2;
         ST_WR_STALL: state_d = ST_RD;
         default: begin
            if (collide)       state_d = ST_WR_STALL;
            else if (err_take) state_d = ST_ERR1;
            else if (wr_take)  state_d = ST_WR;
            else if (rd_take)  state_d = ST_RD;
            else               state_d = ST_IDLE;
         end
      endcase
      if (wr_take) begin
         waddr_d = haddr_word;
         sel_d   = dec_sel;
      end
   end

   // Output logic
   always_comb begin
      HREADYOUT  = 1'b1;
      HRESP      = HRESP_OKAY;
      HRDATA     = '0;
      sram_ce    = 1'b0;
      sram_we    = 1'b0;
      sram_oe    = 1'b0;
      sram_waddr = '0;
      sram_din   = '0;
      sram_sel   = '0;
      case (state_q)
         ST_RD: HRDATA = sram_dout;
         ST_WR: begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_waddr = waddr_q;
            sram_din   = HWDATA;
            sram_sel   = sel_q;
            if (collide) HREADYOUT = 1'b0;
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
         end
         ST_ERR2: HRESP = HRESP_ERROR;
         default: ;
      endcase
      // Never overlaps the WR strobe: a read during WR is a collision.
      if (rd_issue) begin
         sram_ce    = 1'b1;
         sram_oe    = 1'b1;
         sram_waddr = haddr_word;
         sram_sel   = dec_sel;
      end
   end

endmodule

// File: tb/tb_soc_ahb3_sram_sp_bridge.sv
module tb_soc_ahb3_sram_sp_bridge;
   import soc_ahb3_pkg::*;

   logic        clk, rst;
   logic        HSEL, HWRITE, HMASTLOCK, HREADY;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic        HREADYOUT, HRESP;
   logic        sram_ce, sram_we, sram_oe;
   logic [29:0] sram_waddr;
   logic [31:0] sram_din, sram_dout;
   logic [3:0]  sram_sel;

   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;
   int we_base;

   logic [31:0] mem [0:255];

   assign HREADY = HREADYOUT;

   soc_ahb3_sram_sp_bridge dut (
      .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
      .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY),
      .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe),
      .sram_waddr(sram_waddr), .sram_din(sram_din), .sram_sel(sram_sel),
      .sram_dout(sram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port SRAM model, 1-cycle read latency
   always @(posedge clk) begin
      if (sram_ce && sram_we)
         for (int b = 0; b < 4; b++)
            if (sram_sel[b]) mem[sram_waddr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
      if (sram_ce && sram_oe) sram_dout <= mem[sram_waddr[7:0]];
   end

   always @(posedge clk) if (sram_we) we_cnt <= we_cnt + 1;

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   task automatic ap(input logic s, input logic [1:0] t, input logic w,
                     input logic [2:0] sz, input logic [31:0] a);
      HSEL = s; HTRANS = t; HWRITE = w; HSIZE = sz; HADDR = a;
   endtask

   task automatic test_reset();
      rst = 1'b1; HWDATA = '0;
      ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_BYTE, 32'h0);
      @(negedge clk);
      n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_bad++; $display("FAIL rst_hready_hresp act=%b req=10", {HREADYOUT, HRESP}); end
      n_cmp++; if (HRDATA !== 32'h0) begin n_bad++; $display("FAIL rst_hrdata act=%h req=0", HRDATA); end
      n_cmp++; if ({sram_ce, sram_we, sram_oe, sram_sel} !== 7'b0) begin n_bad++; $display("FAIL rst_ctl act=%b req=0", {sram_ce, sram_we, sram_oe, sram_sel}); end
      n_cmp++; if ({sram_waddr, sram_din} !== 62'h0) begin n_bad++; $display("FAIL rst_addr_din act=%h/%h req=0/0", sram_waddr, sram_din); end
      n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL rst_state act=%0d req=%0d", dut.state_q, ST_IDLE); end
      ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
      #1;
      n_cmp++; if (sram_ce !== 1'b0) begin n_bad++; $display("FAIL rst_rd_blocked act=%b req=0", sram_ce); end
      nxt(); rst = 1'b0;
      ap(1'b0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
      @(negedge clk);
      n_cmp++; if ({sram_ce, HREADYOUT} !== 2'b01) begin n_bad++; $display("FAIL unsel_no_access act=%b req=01", {sram_ce, HREADYOUT}); end
      nxt(); ap(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
      @(negedge clk);
   endtask

   task automatic test_word_rw();
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
      @(negedge clk);
      n_cmp++; if ({sram_ce, HREADYOUT} !== 2'b01) begin n_bad++; $display("FAIL wr_ap act=%b req=01", {sram_ce, HREADYOUT}); end
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0); HWDATA = 32'h12345678;
      @(negedge clk);
      n_cmp++; if ({sram_ce, sram_we, sram_oe, sram_sel, HREADYOUT} !== 8'b110_1111_1) begin n_bad++; $display("FAIL wr_dp_ctl act=%b req=11011111", {sram_ce, sram_we, sram_oe, sram_sel, HREADYOUT}); end
      n_cmp++; if (sram_waddr !== 30'd4) begin n_bad++; $display("FAIL wr_dp_waddr act=%h req=4", sram_waddr); end
      n_cmp++; if (sram_din !== 32'h12345678) begin n_bad++; $display("FAIL wr_dp_din act=%h req=12345678", sram_din); end
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
      @(negedge clk);
      n_cmp++; if ({sram_ce, sram_we, sram_oe, HREADYOUT} !== 4'b1011) begin n_bad++; $display("FAIL rd_ap_ctl act=%b req=1011", {sram_ce, sram_we, sram_oe, HREADYOUT}); end
      n_cmp++; if (sram_waddr !== 30'd4) begin n_bad++; $display("FAIL rd_ap_waddr act=%h req=4", sram_waddr); end
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
      @(negedge clk);
      n_cmp++; if ({HRDATA, HREADYOUT, HRESP} !== {32'h12345678, 2'b10}) begin n_bad++; $display("FAIL rd_dp act=%h/%b%b req=12345678/10", HRDATA, HREADYOUT, HRESP); end
   endtask

   task automatic test_byte_write();
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h13);
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0); HWDATA = 32'hAB000000;
      @(negedge clk);
      n_cmp++; if ({sram_we, sram_sel} !== 5'b1_1000) begin n_bad++; $display("FAIL bwr_sel act=%b req=11000", {sram_we, sram_sel}); end
      n_cmp++; if (sram_waddr !== 30'd4) begin n_bad++; $display("FAIL bwr_waddr act=%h req=4", sram_waddr); end
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
      @(negedge clk);
      n_cmp++; if (HRDATA !== 32'hAB345678) begin n_bad++; $display("FAIL bwr_readback act=%h req=ab345678", HRDATA); end
   endtask

   task automatic test_wr_rd_collision();
      we_base = we_cnt;
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20);
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20); HWDATA = 32'h5A5AA5A5;
      @(negedge clk);
      n_cmp++; if ({HREADYOUT, sram_we, sram_oe} !== 3'b010) begin n_bad++; $display("FAIL col_wr act=%b req=010", {HREADYOUT, sram_we, sram_oe}); end
      n_cmp++; if ({sram_waddr, sram_din} !== {30'd8, 32'h5A5AA5A5}) begin n_bad++; $display("FAIL col_wr_data act=%h/%h req=8/5a5aa5a5", sram_waddr, sram_din); end
      nxt();
      @(negedge clk);
      n_cmp++; if ({HREADYOUT, sram_ce, sram_we, sram_oe} !== 4'b1101) begin n_bad++; $display("FAIL col_stall act=%b req=1101", {HREADYOUT, sram_ce, sram_we, sram_oe}); end
      n_cmp++; if (sram_waddr !== 30'd8) begin n_bad++; $display("FAIL col_stall_waddr act=%h req=8", sram_waddr); end
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
      @(negedge clk);
      n_cmp++; if ({HRDATA, HREADYOUT} !== {32'h5A5AA5A5, 1'b1}) begin n_bad++; $display("FAIL col_rdata act=%h/%b req=5a5aa5a5/1", HRDATA, HREADYOUT); end
      n_cmp++; if (we_cnt - we_base !== 1) begin n_bad++; $display("FAIL col_we_pulses act=%0d req=1", we_cnt - we_base); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [4];
      d[0] = 32'h11111111; d[1] = 32'h22222222; d[2] = 32'h33333333; d[3] = 32'h44444444;
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0);
      for (int k = 0; k < 4; k++) begin
         nxt();
         if (k < 3) ap(1'b1, HTRANS_SEQ, 1'b1, HSIZE_WORD, 32'(4 * (k + 1)));
         else       ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
         HWDATA = d[k];
         @(negedge clk);
         n_cmp++; if ({HREADYOUT, sram_we, sram_waddr, sram_din} !== {1'b1, 1'b1, 30'(k), d[k]}) begin n_bad++; $display("FAIL b2b_wr%0d act=%b%b/%h/%h req=11/%h/%h", k, HREADYOUT, sram_we, sram_waddr, sram_din, k, d[k]); end
      end
   endtask

   task automatic test_errors();
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10000);
      @(negedge clk);
      n_cmp++; if (sram_ce !== 1'b0) begin n_bad++; $display("FAIL err_range_no_ce act=%b req=0", sram_ce); end
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
      @(negedge clk);
      n_cmp++; if ({HREADYOUT, HRESP, sram_ce} !== 3'b010) begin n_bad++; $display("FAIL err_range_c1 act=%b req=010", {HREADYOUT, HRESP, sram_ce}); end
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HWORD, 32'h1);
      @(negedge clk);
      n_cmp++; if ({HREADYOUT, HRESP, sram_ce} !== 3'b110) begin n_bad++; $display("FAIL err_range_c2 act=%b req=110", {HREADYOUT, HRESP, sram_ce}); end
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
      @(negedge clk);
      n_cmp++; if ({HREADYOUT, HRESP, sram_ce} !== 3'b010) begin n_bad++; $display("FAIL err_mis_c1 act=%b req=010", {HREADYOUT, HRESP, sram_ce}); end
      nxt();
      @(negedge clk);
      n_cmp++; if ({HREADYOUT, HRESP, sram_ce} !== 3'b110) begin n_bad++; $display("FAIL err_mis_c2 act=%b req=110", {HREADYOUT, HRESP, sram_ce}); end
      nxt();
      @(negedge clk);
      n_cmp++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_bad++; $display("FAIL err_recover act=%b req=10", {HREADYOUT, HRESP}); end
   endtask

   task automatic test_incr_busy();
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
      @(negedge clk);
      n_cmp++; if ({sram_ce, sram_oe, sram_waddr, HREADYOUT} !== {2'b11, 30'd0, 1'b1}) begin n_bad++; $display("FAIL incr_b0 act=%b%b/%h/%b req=11/0/1", sram_ce, sram_oe, sram_waddr, HREADYOUT); end
      nxt(); ap(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h4);
      @(negedge clk);
      n_cmp++; if ({HRDATA, HREADYOUT, HRESP, sram_waddr} !== {32'h11111111, 2'b10, 30'd1}) begin n_bad++; $display("FAIL incr_b1 act=%h/%b%b/%h req=11111111/10/1", HRDATA, HREADYOUT, HRESP, sram_waddr); end
      nxt(); ap(1'b1, HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h8);
      @(negedge clk);
      n_cmp++; if ({HRDATA, HREADYOUT, sram_ce} !== {32'h22222222, 2'b10}) begin n_bad++; $display("FAIL incr_busy act=%h/%b/%b req=22222222/1/0", HRDATA, HREADYOUT, sram_ce); end
      nxt(); ap(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h8);
      @(negedge clk);
      n_cmp++; if ({HRDATA, sram_ce, sram_waddr, HREADYOUT} !== {32'h0, 1'b1, 30'd2, 1'b1}) begin n_bad++; $display("FAIL incr_b2 act=%h/%b/%h/%b req=0/1/2/1", HRDATA, sram_ce, sram_waddr, HREADYOUT); end
      nxt(); ap(1'b1, HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'hC);
      @(negedge clk);
      n_cmp++; if ({HRDATA, sram_waddr, HREADYOUT} !== {32'h33333333, 30'd3, 1'b1}) begin n_bad++; $display("FAIL incr_b3 act=%h/%h/%b req=33333333/3/1", HRDATA, sram_waddr, HREADYOUT); end
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
      @(negedge clk);
      n_cmp++; if ({HRDATA, HREADYOUT, HRESP} !== {32'h44444444, 2'b10}) begin n_bad++; $display("FAIL incr_last act=%h/%b%b req=44444444/10", HRDATA, HREADYOUT, HRESP); end
   endtask

   task automatic test_reset_mid_write();
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30);
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0); HWDATA = 32'hCAFEF00D;
      nxt(); ap(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30);
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0); HWDATA = 32'hDEADBEEF;
      we_base = we_cnt;
      @(negedge clk);
      n_cmp++; if (sram_we !== 1'b1) begin n_bad++; $display("FAIL rstwr_pre_we act=%b req=1", sram_we); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if ({sram_we, sram_ce, HREADYOUT} !== 3'b001) begin n_bad++; $display("FAIL rstwr_async act=%b req=001", {sram_we, sram_ce, HREADYOUT}); end
      n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL rstwr_state act=%0d req=%0d", dut.state_q, ST_IDLE); end
      nxt(); rst = 1'b0;
      ap(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30);
      nxt(); ap(1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
      @(negedge clk);
      n_cmp++; if (HRDATA !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rstwr_mem act=%h req=cafef00d", HRDATA); end
      n_cmp++; if (we_cnt - we_base !== 0) begin n_bad++; $display("FAIL rstwr_we_pulses act=%0d req=0", we_cnt - we_base); end
   endtask

   initial begin
      HBURST = 3'b011; HPROT = 4'b0011; HMASTLOCK = 1'b0;
      test_reset();
      test_word_rw();
      test_byte_write();
      test_wr_rd_collision();
      test_back_to_back();
      test_errors();
      test_incr_busy();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/soc_ahb3_sram_sp_bridge.md
Name: soc_ahb3_sram_sp_bridge

Overview:
- AHB3-Lite slave that converts bus transfers into single-port SRAM accesses for the SoC on-chip memory.
- Sits directly upstream of the plain single-port SRAM and drives its ce/we/oe/waddr/din/sel; consumes its dout, which has 1-cycle read latency.
- Reads complete with zero wait states.
- Writes are issued in the AHB data phase; one wait state is inserted only when a read address phase collides with a write data phase.
- Out-of-range or misaligned transfers get a two-cycle ERROR response.

Parameters:
- PLEN, 32, byte address width
- XLEN, 32, data width; legal values 8/16/32; SW = XLEN/8 (localparam)
- WORD_AW, PLEN-(SW>>1), SRAM word address width
- MEM_SIZE_BYTE, 'h10000, memory size in bytes; byte addresses >= MEM_SIZE_BYTE give ERROR

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  PLEN  byte address
- HWDATA  in  XLEN  write data (data phase)
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type (ignored, every beat decoded independently)
- HPROT  in  4  protection (ignored)
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus ready
- HRDATA  out  XLEN  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- sram_ce  out  1  chip enable
- sram_we  out  1  write enable
- sram_oe  out  1  output enable
- sram_waddr  out  WORD_AW  word address
- sram_din  out  XLEN  write data
- sram_sel  out  SW  byte selects
- sram_dout  in  XLEN  SRAM read data

Behaviour:
- Accept condition: HSEL & HREADY & HTRANS in {NONSEQ,SEQ}. IDLE/BUSY or unselected: OKAY, zero wait, no SRAM access.
- Lane decode, little-endian:
  - byte: sel = 1<<HADDR[off]
  - half: sel = 2'b11 shifted by 2*HADDR[1]
  - word: sel = all ones
  - off = HADDR[(SW>>1)-1:0]
- Error cases: HSIZE > log2(SW), misaligned half/word, or HADDR >= MEM_SIZE_BYTE. These are never sent to the SRAM.
- Word address = HADDR >> (SW>>1), truncated to WORD_AW.
- FSM states: IDLE, RD, WR, WR_STALL, ERR1, ERR2.
- Read accepted in cycle N:
  - same cycle: sram_ce=1, sram_oe=1, sram_we=0, sram_waddr from HADDR (combinational); state->RD
  - cycle N+1: HRDATA=sram_dout, HREADYOUT=1
- Write accepted in cycle N:
  - register word address and sel; state->WR
  - cycle N+1: sram_ce=1, sram_we=1, sram_din=HWDATA
- WR collision: if a read is accepted in the same cycle as a WR data phase:
  - drive HREADYOUT=0 and do not start the read; state->WR_STALL
  - in WR_STALL: no write, issue the held read (HADDR is stable per protocol), HREADYOUT=1, state->RD
- Back-to-back writes: WR->WR with no stall; the new address is registered while the previous data is written.
- Error handling:
  - error accepted: state->ERR1
  - ERR1: HREADYOUT=0, HRESP=1
  - ERR2: HREADYOUT=1, HRESP=1, then per accept condition
- Output defaults:
  - HRDATA = 0 outside RD
  - sram_ce/we/oe = 0 when there is no access
  - HRESP = 0 except in ERR1/ERR2
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, sram_ce/we/oe=0, sram_waddr/din/sel=0, state IDLE.
- Reset mid-operation: pending write dropped, FSM to IDLE immediately (async).

Decomposition:
- Shared package soc_ahb3_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HSIZE_BYTE/HWORD/WORD
  - HRESP_OKAY/ERROR
  - bridge state enum typedef
- One sub-module, soc_ahb3_sram_lane_decode: combinational HSIZE/HADDR -> sel, misalign flag, size-error flag.

Test Plan:
- Write word 0x12345678 @0x10, then read @0x10 -> write cycle sram_we=1, sram_sel=4'hF, sram_waddr=4; read data phase HRDATA=0x12345678, no wait states.
- Byte write 0xAB @0x13 (HWDATA=0xAB000000), then word read @0x10 -> sram_sel=4'b1000; HRDATA=0xAB345678.
- Write @0x20 immediately followed by read @0x20 -> one cycle HREADYOUT=0 (WR_STALL), read returns the newly written data, exactly one sram_we pulse.
- Read @MEM_SIZE_BYTE; then halfword @0x1 -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; sram_ce stays 0.
- Four-beat INCR4 word reads @0x0..0xC with an interleaved BUSY -> four zero-wait OKAY responses, no SRAM access in the BUSY cycle.
- Assert rst during a WR data phase -> sram_we=0 immediately, HREADYOUT=1, state IDLE; memory location unchanged.
